boot_load_ctrl: RTL and testbench



---
 rtl/boot_load_ctrl_pkg.sv | 26 ++
 rtl/inter_byte_timer.sv | 37 +++
 rtl/boot_load_ctrl.sv | 133 +++++++++++++
 tb/tb_boot_load_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : boot_load_ctrl_pkg
// Brief    : Shared types and constants for the program-load controller.
// Revision : 1.0 - initial release
// ============================================================================
package boot_load_ctrl_pkg;

   // Controller states; the encoding is exported on state_dbg.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LEN_LO  = 3'd1,
      LEN_HI  = 3'd2,
      PAYLOAD = 3'd3,
      CHECK   = 3'd4,
      DONE    = 3'd5,
      ERROR   = 3'd6
   } boot_state_t;

   localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;

   // Payload index width; covers 0..1024.
   localparam int INDEX_W = 11;

endpackage : boot_load_ctrl_pkg
`default_nettype wire

// File: rtl/inter_byte_timer.sv
`default_nettype none
// ============================================================================
// Module   : inter_byte_timer
// Brief    : Down-counter that flags a gap of CYCLES clocks without a kick.
//            Reloads whenever kicked or disabled.
// Revision : 1.0 - initial release
// ============================================================================
module inter_byte_timer #(
   parameter int CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic kick,
   output logic expired
);

   localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

   logic [W-1:0] remaining;

   // Count down while armed; any received byte or leaving the frame reloads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         remaining <= LOAD;
      end else if (kick || !enable) begin
         remaining <= LOAD;
      end else if (remaining != '0) begin
         remaining <= remaining - 1'b1;
      end
   end

   assign expired = enable && (remaining == '0);

endmodule : inter_byte_timer
`default_nettype wire

// File: rtl/boot_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : boot_load_ctrl
// Brief    : Parses SYNC/LEN/PAYLOAD/CHK frames from the UART, writes the
//            payload into instruction memory and holds the CPU in reset until
//            a frame has loaded with a matching checksum.
// Revision : 1.0 - initial release
// ============================================================================
module boot_load_ctrl
   import boot_load_ctrl_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = BOOT_SYNC_BYTE,
   parameter int         MAX_BYTES      = 1024,
   parameter int         TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        cpu_rstn,
   output logic        load_done,
   output logic        load_error,
   output logic [2:0]  state_dbg
);

   boot_state_t        state;
   boot_state_t        state_next;
   logic [7:0]         len_lo;
   logic [INDEX_W-1:0] len;
   logic [INDEX_W-1:0] index;
   logic [7:0]         sum;

   logic [15:0]        len_full;
   logic               len_ok;
   logic               last_byte;
   logic               timed;
   logic               expired;

   assign len_full  = {rx_data, len_lo};
   assign len_ok    = (len_full != 16'd0) && (len_full <= 16'(MAX_BYTES));
   assign last_byte = (index == len - 1'b1);
   assign timed     = (state == LEN_LO) || (state == LEN_HI) ||
                      (state == PAYLOAD) || (state == CHECK);

   inter_byte_timer #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .enable  (timed),
      .kick    (rx_valid),
      .expired (expired)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode; a byte arriving on the expiry cycle takes priority.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, DONE, ERROR: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) state_next = LEN_LO;
         end
         LEN_LO: begin
            if (rx_valid) state_next = LEN_HI;
         end
         LEN_HI: begin
            if (rx_valid) state_next = len_ok ? PAYLOAD : ERROR;
         end
         PAYLOAD: begin
            if (rx_valid && last_byte) state_next = CHECK;
         end
         CHECK: begin
            if (rx_valid) state_next = (rx_data == sum) ? DONE : ERROR;
         end
         default: state_next = IDLE;
      endcase
      if (timed && !rx_valid && expired) state_next = ERROR;
   end

   // Frame datapath and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_lo     <= '0;
         len        <= '0;
         index      <= '0;
         sum        <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_rstn   <= 1'b0;
         load_done  <= 1'b0;
         load_error <= 1'b0;
      end else begin
         mem_we     <= 1'b0;
         cpu_rstn   <= (state_next == DONE);
         load_done  <= (state_next == DONE);
         load_error <= (state_next == ERROR);
         if (rx_valid) begin
            unique case (state)
               LEN_LO: len_lo <= rx_data;
               LEN_HI: begin
                  len   <= len_full[INDEX_W-1:0];
                  index <= '0;
                  sum   <= '0;
               end
               PAYLOAD: begin
                  mem_we    <= 1'b1;
                  mem_addr  <= {{(32-INDEX_W){1'b0}}, index};
                  mem_wdata <= rx_data;
                  sum       <= sum + rx_data;
                  index     <= index + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign state_dbg = state;

endmodule : boot_load_ctrl
`default_nettype wire

// File: tb/tb_boot_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_load_ctrl
// Brief    : Self-checking bench for boot_load_ctrl: table vectors, corner
//            sequences and random frames against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_load_ctrl;

   localparam int MAX_BYTES      = 1024;
   localparam int TIMEOUT_CYCLES = 16;
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LEN_LO  = 3'd1;
   localparam logic [2:0] S_PAYLOAD = 3'd3;
   localparam logic [2:0] S_CHECK   = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;
   localparam logic [2:0] S_ERROR   = 3'd6;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data  = 8'h00;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        cpu_rstn;
   logic        load_done;
   logic        load_error;
   logic [2:0]  state_dbg;

   always #5 clk = ~clk;

   boot_load_ctrl #(
      .SYNC_BYTE      (8'hA5),
      .MAX_BYTES      (MAX_BYTES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_rstn   (cpu_rstn),
      .load_done  (load_done),
      .load_error (load_error),
      .state_dbg  (state_dbg)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [39:0] wr_q[$];
   logic [39:0] exp_q[$];
   logic [7:0]  frame_q[$];
   logic        exp_done;

   typedef struct packed {
      logic [95:0] bytes;   // first byte in the top bits
      int          n;
      int          exp_we;
      logic        exp_done;
   } vec_t;

   vec_t vecs[7];

   // Capture every memory write strobe.
   always @(negedge clk) begin
      if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input int gap_max);
      for (int i = 0; i < frame_q.size(); i++) begin
         send_byte(frame_q[i]);
         if (gap_max > 0) idle($urandom_range(0, gap_max));
      end
   endtask

   // Frame-level reference: skip non-sync bytes, decode N, expect every
   // payload byte written at its index, done only if the checksum matches.
   task automatic model();
      int p;
      int n;
      logic [7:0] s;
      exp_q.delete();
      exp_done = 1'b0;
      p = 0;
      while (p < frame_q.size() && frame_q[p] != 8'hA5) p++;
      if (p + 3 > frame_q.size()) return;
      n = int'(frame_q[p+1]) + 256 * int'(frame_q[p+2]);
      if (n == 0 || n > MAX_BYTES) return;
      s = 8'h00;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({32'(i), frame_q[p+3+i]});
         s = s + frame_q[p+3+i];
      end
      exp_done = (frame_q[p+3+n] == s);
   endtask

   task automatic check_frame(input string name, input int exp_cnt, input logic done);
      check({name, " write count"}, wr_q.size(), exp_cnt);
      for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
         check({name, " write"}, wr_q[i], exp_q[i]);
      check({name, " load_done"},  load_done,  done);
      check({name, " load_error"}, load_error, !done);
      check({name, " cpu_rstn"},   cpu_rstn,   done);
      wr_q.delete();
   endtask

   task automatic build_random();
      int n;
      int kind;
      logic [7:0] s;
      logic [7:0] b;
      frame_q.delete();
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
         b = 8'($urandom_range(0, 255));
         frame_q.push_back(b == 8'hA5 ? 8'h00 : b);
      end
      kind = $urandom_range(0, 9);
      if (kind == 0)      n = 0;
      else if (kind == 1) n = MAX_BYTES + 1 + $urandom_range(0, 200);
      else                n = $urandom_range(1, 8);
      frame_q.push_back(8'hA5);
      frame_q.push_back(n[7:0]);
      frame_q.push_back(n[15:8]);
      if (n >= 1 && n <= MAX_BYTES) begin
         s = 8'h00;
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            frame_q.push_back(b);
            s = s + b;
         end
         if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
         frame_q.push_back(s);
      end
   endtask

   initial begin
      vecs[0] = '{96'hA5_04_00_13_00_00_00_13_00_00_00_00, 8, 4, 1'b1};
      vecs[1] = '{96'hA5_04_00_13_00_00_00_14_00_00_00_00, 8, 4, 1'b0};
      vecs[2] = '{96'hA5_04_00_13_00_00_00_13_00_00_00_00, 8, 4, 1'b1};
      vecs[3] = '{96'hA5_00_00_00_00_00_00_00_00_00_00_00, 3, 0, 1'b0};
      vecs[4] = '{96'hA5_01_04_00_00_00_00_00_00_00_00_00, 3, 0, 1'b0};
      vecs[5] = '{96'h00_FF_A5_02_00_11_22_33_00_00_00_00, 8, 2, 1'b1};
      vecs[6] = '{96'hA5_01_00_FF_FF_00_00_00_00_00_00_00, 5, 1, 1'b1};

      // Reset values
      idle(3);
      check("reset mem_we",     mem_we,     0);
      check("reset mem_addr",   mem_addr,   0);
      check("reset mem_wdata",  mem_wdata,  0);
      check("reset cpu_rstn",   cpu_rstn,   0);
      check("reset load_done",  load_done,  0);
      check("reset load_error", load_error, 0);
      check("reset state",      state_dbg,  S_IDLE);
      reset = 1'b0;
      tick();

      // Table vectors, bytes back-to-back
      foreach (vecs[k]) begin
         frame_q.delete();
         for (int i = 0; i < vecs[k].n; i++) frame_q.push_back(vecs[k].bytes[95-8*i -: 8]);
         model();
         send_frame(0);
         idle(2);
         check_frame($sformatf("vec%0d", k), vecs[k].exp_we, vecs[k].exp_done);
      end
      check("done state", state_dbg, S_DONE);

      // Reload from DONE drops the CPU reset on the next cycle
      send_byte(8'hA5);
      check("reload cpu_rstn",  cpu_rstn,  0);
      check("reload load_done", load_done, 0);
      check("reload state",     state_dbg, S_LEN_LO);
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h07); send_byte(8'h07);
      check("reload release cpu_rstn",  cpu_rstn,  1);
      check("reload release load_done", load_done, 1);
      wr_q.delete();

      // Timeout after 16 silent cycles in PAYLOAD; single-cycle strobe
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h11);
      check("strobe mem_we",    mem_we,    1);
      check("strobe mem_addr",  mem_addr,  0);
      check("strobe mem_wdata", mem_wdata, 8'h11);
      idle(1);
      check("strobe drop mem_we",    mem_we,    0);
      check("strobe hold mem_addr",  mem_addr,  0);
      check("strobe hold mem_wdata", mem_wdata, 8'h11);
      idle(TIMEOUT_CYCLES - 2);
      check("pre-timeout state",      state_dbg,  S_PAYLOAD);
      check("pre-timeout load_error", load_error, 0);
      idle(1);
      check("timeout state",      state_dbg,  S_ERROR);
      check("timeout load_error", load_error, 1);
      check("timeout cpu_rstn",   cpu_rstn,   0);

      // Byte arriving on the expiry cycle wins
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h11);
      idle(TIMEOUT_CYCLES - 1);
      send_byte(8'h22);
      check("expiry byte state",      state_dbg,  S_CHECK);
      check("expiry byte load_error", load_error, 0);
      send_byte(8'h33);
      check("expiry frame load_done", load_done, 1);
      wr_q.delete();

      // Asynchronous reset mid-payload
      send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00); send_byte(8'h13);
      check("pre-reset mem_we", mem_we, 1);
      #1 reset = 1'b1;
      #1;
      check("async reset mem_we",    mem_we,    0);
      check("async reset mem_wdata", mem_wdata, 0);
      check("async reset state",     state_dbg, S_IDLE);
      check("async reset cpu_rstn",  cpu_rstn,  0);
      idle(2);
      reset = 1'b0;
      tick();
      wr_q.delete();
      frame_q = '{8'hA5, 8'h01, 8'h00, 8'h5A, 8'h5A};
      model();
      send_frame(0);
      idle(2);
      check_frame("after reset", exp_q.size(), exp_done);

      // Largest legal payload, back-to-back
      frame_q.delete();
      frame_q.push_back(8'hA5); frame_q.push_back(8'h00); frame_q.push_back(8'h04);
      begin
         logic [7:0] s;
         logic [7:0] b;
         s = 8'h00;
         for (int i = 0; i < MAX_BYTES; i++) begin
            b = 8'($urandom_range(0, 255));
            frame_q.push_back(b);
            s = s + b;
         end
         frame_q.push_back(s);
      end
      model();
      send_frame(0);
      idle(2);
      check_frame("max length", MAX_BYTES, 1'b1);

      // Random frames with gaps below the timeout
      for (int f = 0; f < 40; f++) begin
         build_random();
         model();
         send_frame(3);
         idle(2);
         check_frame($sformatf("random%0d", f), exp_q.size(), exp_done);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_boot_load_ctrl
`default_nettype wire
